// File: rtl/wb_gpio_bank.sv
// Wishbone-mapped LED/button bank with edge capture and a level interrupt.
// Define GPIO_DEBOUNCE_EN to add per-button debounce counters (DEBOUNCE_CYCLES).
module wb_gpio_bank #(
    parameter int unsigned N_LEDS          = 4,
    parameter int unsigned N_BUTTONS       = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [31:0]          i_wb_addr,
    input  logic [31:0]          i_wb_data,
    output logic                 o_wb_ack,
    output logic                 o_wb_stall,
    output logic [31:0]          o_wb_data,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] buttons_enb,
    output logic [N_LEDS-1:0]    led_enb,
    output logic [N_LEDS-1:0]    leds,
    output logic                 irq
);
    localparam int unsigned CNT_W      = 16;
    localparam logic [1:0]  REG_LED    = 2'd0;
    localparam logic [1:0]  REG_BTN    = 2'd1;
    localparam logic [1:0]  REG_EDGE   = 2'd2;
    localparam logic [1:0]  REG_IRQ_EN = 2'd3;

    logic [N_BUTTONS-1:0] r_sync1, r_sync2, r_btn_prev, r_edge, r_irq_en;
    logic [N_BUTTONS-1:0] w_btn_db, w_rise, w_edge_clr;
    logic [N_LEDS-1:0]    r_leds;
    logic                 r_ack, r_irq;
    logic [31:0]          r_rdata, w_rdata, w_off;
    logic                 w_hit;
    logic [1:0]           w_reg;
    logic                 w_unused;

    // Offset-based decode keeps any word-aligned base working, not only 16-byte aligned ones.
    assign w_off    = i_wb_addr - BASE_ADDR;
    assign w_hit    = i_wb_cyc && i_wb_stb && (w_off[31:4] == 28'd0) && (w_off[1:0] == 2'b00);
    assign w_reg    = w_off[3:2];
    assign w_unused = ^i_wb_data;

`ifdef GPIO_DEBOUNCE_EN
    logic [CNT_W-1:0]     r_cnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] r_btn_db;

    // A button only changes state after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_db <= '0;
            for (int i = 0; i < int'(N_BUTTONS); i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_BUTTONS); i++) begin
                if (r_sync2[i] == r_btn_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEBOUNCE_CYCLES - CNT_W'(1)) begin
                    r_btn_db[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_btn_db = r_btn_db;
`else
    logic w_unused_db;

    assign w_btn_db    = r_sync2;
    assign w_unused_db = ^DEBOUNCE_CYCLES;
`endif

    assign w_rise     = w_btn_db & ~r_btn_prev;
    assign w_edge_clr = (w_hit && i_wb_we && (w_reg == REG_EDGE)) ? i_wb_data[N_BUTTONS-1:0]
                                                                  : '0;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_LED:  w_rdata = 32'(r_leds);
            REG_BTN:  w_rdata = 32'(w_btn_db);
            REG_EDGE: w_rdata = 32'(r_edge);
            default:  w_rdata = 32'(r_irq_en);
        endcase
    end

    // Synchronisers hold the inverted pad level so that 1 means pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_btn_prev <= '0;
            r_edge     <= '0;
            r_irq_en   <= '0;
            r_leds     <= '0;
            r_ack      <= 1'b0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_sync1    <= ~buttons;
            r_sync2    <= r_sync1;
            r_btn_prev <= w_btn_db;
            r_edge     <= (r_edge & ~w_edge_clr) | w_rise;
            r_irq      <= |(r_edge & r_irq_en);
            r_ack      <= w_hit;
            if (w_hit) r_rdata <= w_rdata;
            if (w_hit && i_wb_we) begin
                if (w_reg == REG_LED)    r_leds   <= i_wb_data[N_LEDS-1:0];
                if (w_reg == REG_IRQ_EN) r_irq_en <= i_wb_data[N_BUTTONS-1:0];
            end
        end
    end

    assign o_wb_ack    = r_ack;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = r_rdata;
    assign buttons_enb = '1;
    assign led_enb     = '0;
    assign leds        = r_leds;
    assign irq         = r_irq;
endmodule

// File: tb/tb_wb_gpio_bank.sv
// Bench for wb_gpio_bank: directed scenarios plus random traffic against a
// cycle-level reference model built from sample histories.
module tb_wb_gpio_bank;
    localparam int          NL   = 4;
    localparam int          NB   = 4;
    localparam int          D    = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0]   i_wb_addr, i_wb_data;
    logic          o_wb_ack, o_wb_stall;
    logic [31:0]   o_wb_data;
    logic [NB-1:0] buttons, buttons_enb;
    logic [NL-1:0] led_enb, leds;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    wb_gpio_bank #(
        .N_LEDS(NL), .N_BUTTONS(NB), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16'(D))
    ) dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .buttons(buttons), .buttons_enb(buttons_enb), .led_enb(led_enb),
        .leds(leds), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: pressed samples kept in a history queue (newest first).
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_db_now, m_db_last, m_edge, m_en;
    logic [NL-1:0] m_leds;
    logic          m_ack, m_irq;
    logic [31:0]   m_rdata;
    logic [NB-1:0] mt_rise, mt_clr, mt_nxt, mt_h;
    logic [31:0]   mt_off;
    logic          mt_hit, mt_stable;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_front('0);
            m_db_now  = '0;
            m_db_last = '0;
            m_edge    = '0;
            m_en      = '0;
            m_leds    = '0;
            m_ack     = 1'b0;
            m_irq     = 1'b0;
            m_rdata   = '0;
        end else begin
            mt_rise = m_db_now & ~m_db_last;
            mt_off  = i_wb_addr - BASE;
            mt_hit  = i_wb_cyc && i_wb_stb && (mt_off < 32'd16) && (mt_off % 4 == 0);
            m_irq   = |(m_edge & m_en);
            m_ack   = mt_hit;
            mt_clr  = '0;
            if (mt_hit) begin
                case (mt_off / 4)
                    0:       m_rdata = 32'(m_leds);
                    1:       m_rdata = 32'(m_db_now);
                    2:       m_rdata = 32'(m_edge);
                    default: m_rdata = 32'(m_en);
                endcase
                if (i_wb_we) begin
                    case (mt_off / 4)
                        0:       m_leds = i_wb_data[NL-1:0];
                        2:       mt_clr = i_wb_data[NB-1:0];
                        3:       m_en   = i_wb_data[NB-1:0];
                        default: ;
                    endcase
                end
            end
            m_edge = (m_edge & ~mt_clr) | mt_rise;
            hist.push_front(~buttons);
`ifdef GPIO_DEBOUNCE_EN
            // Flip a bit once the synchronised value has disagreed for D straight samples.
            for (int b = 0; b < NB; b++) begin
                mt_stable = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    mt_h = hist[j];
                    if (mt_h[b] == m_db_now[b]) mt_stable = 1'b0;
                end
                mt_nxt[b] = mt_stable ? ~m_db_now[b] : m_db_now[b];
            end
`else
            mt_nxt = hist[1];
`endif
            void'(hist.pop_back());
            m_db_last = m_db_now;
            m_db_now  = mt_nxt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("ack", 32'(o_wb_ack), 32'(m_ack));
        chk("rdata", o_wb_data, m_rdata);
        chk("leds", 32'(leds), 32'(m_leds));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic wb(input logic we, input logic [31:0] addr, input logic [31:0] data);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        tick();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    initial begin
        logic       found;
        logic [1:0] bi;

        reset     = 1'b0;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
        buttons   = '1;
        #2 reset  = 1'b1;
        tick();
        tick();
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_ack", 32'(o_wb_ack), 32'h0);
        chk("rst_data", o_wb_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("stall", 32'(o_wb_stall), 32'h0);
        chk("btn_enb", 32'(buttons_enb), 32'hF);
        chk("led_enb", 32'(led_enb), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();

        // LED write/readback
        wb(1'b1, BASE, 32'h5);
        chk("led_wr_ack", 32'(o_wb_ack), 32'h1);
        chk("led_wr_leds", 32'(leds), 32'h5);
        tick();
        chk("led_ack_once", 32'(o_wb_ack), 32'h0);
        wb(1'b0, BASE, 32'h0);
        chk("led_rd", o_wb_data, 32'h5);

        // Long press on button 1, then a short glitch
        wb(1'b1, BASE + 32'h8, 32'hF);
        buttons[1] = 1'b0;
        repeat (D + 3) tick();
        wb(1'b0, BASE + 32'h4, 32'h0);
        chk("btn_press", o_wb_data, 32'h2);
        wb(1'b0, BASE + 32'h8, 32'h0);
        chk("edge_press", o_wb_data, 32'h2);
        buttons[1] = 1'b1;
        repeat (D + 5) tick();
        buttons[1] = 1'b0;
        repeat (5) tick();
        buttons[1] = 1'b1;
        wb(1'b0, BASE + 32'h4, 32'h0);
`ifdef GPIO_DEBOUNCE_EN
        chk("btn_glitch", o_wb_data, 32'h0);
`endif
        repeat (D + 5) tick();
        wb(1'b0, BASE + 32'h4, 32'h0);
        chk("btn_released", o_wb_data, 32'h0);

        // Interrupt raise and W1C clear
        wb(1'b1, BASE + 32'hC, 32'h2);
        wb(1'b1, BASE + 32'h8, 32'hF);
        buttons[1] = 1'b0;
        repeat (D + 6) tick();
        chk("irq_set", 32'(irq), 32'h1);
        wb(1'b1, BASE + 32'h8, 32'h2);
        tick();
        chk("irq_clr", 32'(irq), 32'h0);
        wb(1'b0, BASE + 32'h8, 32'h0);
        chk("edge_clr", o_wb_data, 32'h0);
        buttons[1] = 1'b1;
        repeat (D + 5) tick();

        // W1C colliding with a fresh edge on button 0
        buttons[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 4 * D && !found; c++) begin
            tick();
            if (m_db_now[0] && !m_db_last[0]) found = 1'b1;
        end
        chk("collide_found", 32'(found), 32'h1);
        wb(1'b1, BASE + 32'h8, 32'h1);
        wb(1'b0, BASE + 32'h8, 32'h0);
        chk("collide_edge", o_wb_data, 32'h1);
        buttons[0] = 1'b1;
        repeat (D + 5) tick();

        // Undecoded address never acks
        wb(1'b0, BASE + 32'h10, 32'h0);
        chk("undec_ack0", 32'(o_wb_ack), 32'h0);
        for (int c = 1; c < 4; c++) begin
            tick();
            chk("undec_ack", 32'(o_wb_ack), 32'h0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                bi = 2'($urandom_range(0, NB - 1));
                buttons[bi] = ~buttons[bi];
            end
            i_wb_cyc = ($urandom_range(0, 3) != 0);
            i_wb_stb = 1'($urandom_range(0, 1));
            i_wb_we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                4:       i_wb_addr = BASE + 32'h10;
                5:       i_wb_addr = BASE + 32'h2;
                default: i_wb_addr = BASE + 32'(4 * $urandom_range(0, 3));
            endcase
            i_wb_data = $urandom();
            tick();
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;

        // Reset in the middle of a debounce, with a request pending during reset
        wb(1'b1, BASE, 32'hA);
        wb(1'b0, BASE, 32'h0);
        buttons = '1;
        repeat (D + 5) tick();
        buttons[2] = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_leds", 32'(leds), 32'h0);
        chk("mid_rst_ack", 32'(o_wb_ack), 32'h0);
        chk("mid_rst_data", o_wb_data, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = BASE;
        i_wb_data = 32'hF;
        tick();
        tick();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (D - 2) tick();
        wb(1'b0, BASE + 32'h4, 32'h0);
`ifdef GPIO_DEBOUNCE_EN
        chk("restart_btn", o_wb_data, 32'h0);
`else
        chk("restart_btn", o_wb_data, 32'h4);
`endif
        repeat (6) tick();
        wb(1'b0, BASE + 32'h4, 32'h0);
        chk("restart_btn_late", o_wb_data, 32'h4);
        chk("rst_req_dropped", 32'(leds), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
